// File: rtl/object_buffer_pkg.sv
// cyclops_pkg: shared object descriptor types and buffer sizing for the render front end.
package cyclops_pkg;
    localparam int OBJ_DEPTH = 64;
    typedef struct packed {
        logic signed [9:0] x;
        logic signed [9:0] y;
        logic [11:0]       z;
    } vertex_t;
    typedef struct packed {
        vertex_t v2;
        vertex_t v1;
        vertex_t v0;
    } object_t;
    localparam int OBJ_WIDTH = $bits(object_t);
endpackage

// File: rtl/object_buffer_if.sv
// object_buffer_if: loader/dispatcher side signals of the object buffer; master drives, slave (buffer) responds.
interface object_buffer_if #(parameter int DATA_WIDTH = 96, parameter int IDX_W = 7);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_commit;
    logic                  wr_ready;
    logic                  wr_overflow;
    logic                  next_task;
    logic                  switch_buffer;
    logic [DATA_WIDTH-1:0] task_data;
    logic                  task_valid;
    logic [IDX_W-1:0]      task_index;
    logic                  read_end;
    logic [IDX_W-1:0]      active_count;
    logic                  frame_swapped;
    modport master (
        output wr_en, wr_data, wr_commit, next_task, switch_buffer,
        input  wr_ready, wr_overflow, task_data, task_valid, task_index, read_end, active_count, frame_swapped
    );
    modport slave (
        input  wr_en, wr_data, wr_commit, next_task, switch_buffer,
        output wr_ready, wr_overflow, task_data, task_valid, task_index, read_end, active_count, frame_swapped
    );
endinterface

// File: rtl/object_buffer_ram.sv
// object_ram: simple dual-port descriptor store, one write port and one registered read port; no reset.
module object_ram #(
    parameter int ADDR_W     = 7,
    parameter int DATA_WIDTH = 96
) (
    input  logic                  clock,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_W];
    always_ff @(posedge clock) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    end
endmodule

// File: rtl/object_buffer.sv
// object_buffer: ping-pong descriptor store; loader fills the shadow bank while the active bank is broadcast.
module object_buffer
    import cyclops_pkg::*;
#(
    parameter int DEPTH      = OBJ_DEPTH,
    parameter int DATA_WIDTH = OBJ_WIDTH,
    parameter int IDX_W      = $clog2(DEPTH + 1)
) (
    input  logic clock,
    input  logic reset,
    object_buffer_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    logic r_active, r_committed, r_next_q, r_switch_q, r_task_valid;
    logic r_read_end, r_wr_overflow, r_frame_swapped, r_data_ok;
    logic [IDX_W-1:0] r_rd_ptr, r_active_count, r_shadow_count, r_wr_ptr, r_task_index;
    logic w_adv, w_sw, w_issue, w_wr_full, w_wr_ok, w_commit;
    logic [IDX_W-1:0] w_new_count, w_rd_next;
    logic [DATA_WIDTH-1:0] w_rd_data;
    always_comb begin
        w_adv       = bus.next_task & ~r_next_q;
        w_sw        = bus.switch_buffer & ~r_switch_q;
        w_issue     = w_adv && (r_rd_ptr < r_active_count) && !w_sw;
        w_wr_full   = r_wr_ptr == IDX_W'(DEPTH);
        w_wr_ok     = bus.wr_en && !r_committed && !w_wr_full;
        w_commit    = bus.wr_commit && !r_committed;
        w_new_count = r_committed ? r_shadow_count : r_active_count;
        w_rd_next   = r_rd_ptr + IDX_W'(1);
    end
    object_ram #(.ADDR_W(ADDR_W + 1), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .clock     (clock),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr ({~r_active, r_wr_ptr[ADDR_W-1:0]}),
        .i_wr_data (bus.wr_data),
        .i_rd_en   (w_issue),
        .i_rd_addr ({r_active, r_rd_ptr[ADDR_W-1:0]}),
        .o_rd_data (w_rd_data)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_active        <= 1'b0;
            r_committed     <= 1'b0;
            r_next_q        <= 1'b0;
            r_switch_q      <= 1'b0;
            r_task_valid    <= 1'b0;
            r_read_end      <= 1'b1;
            r_wr_overflow   <= 1'b0;
            r_frame_swapped <= 1'b0;
            r_data_ok       <= 1'b0;
            r_rd_ptr        <= '0;
            r_active_count  <= '0;
            r_shadow_count  <= '0;
            r_wr_ptr        <= '0;
            r_task_index    <= '0;
        end else begin
            r_next_q        <= bus.next_task;
            r_switch_q      <= bus.switch_buffer;
            r_task_valid    <= w_issue;
            r_frame_swapped <= w_sw && r_committed;
            // Swap uses the pre-edge commit state, so a commit landing with sw waits for the next frame.
            if (w_sw) begin
                r_active       <= r_active ^ r_committed;
                r_active_count <= w_new_count;
                r_rd_ptr       <= '0;
                r_read_end     <= w_new_count == '0;
            end else if (w_issue) begin
                r_rd_ptr     <= w_rd_next;
                r_task_index <= r_rd_ptr;
                r_read_end   <= w_rd_next == r_active_count;
                r_data_ok    <= 1'b1;
            end
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + IDX_W'(1);
            if (bus.wr_en && !r_committed && w_wr_full) r_wr_overflow <= 1'b1;
            if (w_commit) begin
                r_shadow_count <= r_wr_ptr + IDX_W'(w_wr_ok);
                r_committed    <= 1'b1;
                r_wr_ptr       <= '0;
            end else if (w_sw && r_committed) begin
                r_committed <= 1'b0;
            end
        end
    end
    // RAM has no reset, so hide its output until the first object is actually issued.
    assign bus.task_data     = r_data_ok ? w_rd_data : '0;
    assign bus.task_valid    = r_task_valid;
    assign bus.task_index    = r_task_index;
    assign bus.read_end      = r_read_end;
    assign bus.active_count  = r_active_count;
    assign bus.frame_swapped = r_frame_swapped;
    assign bus.wr_ready      = !r_committed;
    assign bus.wr_overflow   = r_wr_overflow;
endmodule

// File: doc/object_buffer.md
Name: object_buffer

Overview:
- Double-banked (ping-pong) store of per-frame object descriptors; sits directly upstream of task_dispatcher.
- Host/loader fills the shadow bank while the active bank is broadcast, one object at a time, to all render units.
- Consumes `next_task` (advance) and `switch_buffer` (frame boundary) from the dispatcher.
- Produces `read_end` back to the dispatcher, and `task_data`/`task_valid` to the units.

Parameters:
- DEPTH, 64, max objects per bank (power of two).
- DATA_WIDTH, 96, bits per object descriptor (3 vertices × 32 b).
- IDX_W, $clog2(DEPTH+1), width of counts/indices.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- wr_en  in  1  write one descriptor into shadow bank
- wr_data  in  DATA_WIDTH  descriptor to write
- wr_commit  in  1  shadow bank complete; freeze its count
- wr_ready  out  1  shadow bank accepting writes
- wr_overflow  out  1  sticky: write attempted with shadow bank full
- next_task  in  1  from dispatcher: advance to next object (level, may stay high >1 cycle)
- switch_buffer  in  1  from dispatcher: frame finished (level, may stay high >1 cycle)
- task_data  out  DATA_WIDTH  current object broadcast to units
- task_valid  out  1  one-cycle pulse: new object on task_data
- task_index  out  IDX_W  index of object on task_data
- read_end  out  1  all objects of active bank issued
- active_count  out  IDX_W  object count of active bank
- frame_swapped  out  1  one-cycle pulse: banks swapped

Behaviour:
- Reset values: all outputs 0, except `read_end` = 1 and `wr_ready` = 1. Internal state after reset:
  - active bank 0, read pointer 0;
  - active_count 0, shadow_count 0, wr_ptr 0;
  - committed 0; next_task_q / switch_q 0.
- Edge detect: `adv = next_task & ~next_task_q`; `sw = switch_buffer & ~switch_q`. Both `_q` registers are updated every cycle.
- Issue (condition `adv` && `rd_ptr` < `active_count` && !`sw`):
  - RAM read address is {active, rd_ptr}; synchronous read.
  - Next cycle: `task_valid` = 1 for exactly one cycle; `task_data` = that object; `task_index` = old `rd_ptr`.
  - `rd_ptr` increments. `read_end` is registered `(rd_ptr+1 == active_count)` on the same edge, so it rises together with the last `task_valid`.
  - `task_data`/`task_index` hold their values until the next issue.
- `adv` with `read_end` = 1: ignored, no pulse.
- Frame switch (`sw`):
  - If committed: active bank flips, `active_count` <= `shadow_count`, committed <= 0, `frame_swapped` pulses 1 cycle.
  - If not committed: same bank is replayed.
  - In both cases `rd_ptr` <= 0 and `read_end` <= (new `active_count` == 0).
  - `sw` and `adv` in the same cycle: `sw` wins, `adv` is dropped.
- Write side:
  - `wr_ready` = !committed.
  - `wr_en` && `wr_ready` && `wr_ptr` < DEPTH: write mem[{~active, wr_ptr}], then `wr_ptr`++.
  - `wr_en` && `wr_ptr` == DEPTH: write dropped, `wr_overflow` <= 1 (sticky until reset).
  - `wr_en` while !`wr_ready`: ignored; no overflow flag.
- Commit (`wr_commit` && `wr_ready`): `shadow_count` <= `wr_ptr` + (accepted `wr_en` same cycle ? 1 : 0); committed <= 1; `wr_ptr` <= 0.
- Commit and `sw` in the same cycle: the swap decision uses committed as it was before the edge, so the new commit takes effect on the following `sw`.
- Empty frame: a committed count of 0 is legal. After the swap `read_end` = 1 immediately and no `task_valid` is issued.
- Reset mid-frame: everything returns to reset values; RAM contents are don't-care and unreadable until the next commit + swap.

Decomposition:
- Package `cyclops_pkg`:
  - `vertex_t` {x, y: 10 b signed; z: 12 b};
  - `object_t` = 3 × `vertex_t`, padded to DATA_WIDTH;
  - `OBJ_DEPTH` constant.
- Sub-module `object_ram`: simple dual-port RAM, 2·DEPTH × DATA_WIDTH, one write port, one synchronous read port, no reset.

Test Plan:
- After reset: hold `next_task` high 10 cycles, pulse `switch_buffer` -> `read_end` = 1 throughout, no `task_valid`, no `frame_swapped`.
- Write 3 objects (A, B, C), commit, pulse `switch_buffer` -> `frame_swapped` = 1 for one cycle, `active_count` = 3, `read_end` = 0.
- Then raise `next_task` for 3 cycles -> exactly one `task_valid`, with `task_data` = A, `task_index` = 0.
- Repeat `next_task` rises until the frame is exhausted -> B (index 1), then C (index 2) with `read_end` rising on C's pulse; a 4th rise gives no pulse.
- `switch_buffer` without a new commit -> replay: `read_end` = 0, next rise issues A again, no `frame_swapped`.
- Write DEPTH + 2 objects -> `wr_overflow` = 1. Commit -> `wr_ready` = 0 and further `wr_en` ignored. On swap -> `active_count` = DEPTH.
- Commit with a simultaneous `wr_en` of D after 1 prior write, in the same cycle as `switch_buffer` -> no swap this frame. Next `switch_buffer` swaps, with `active_count` = 2 and D at index 1.
- Commit 0 objects and swap -> `read_end` = 1 immediately, `active_count` = 0, `next_task` produces no `task_valid`.
